// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter. Tag states exist only when
// UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
`ifdef UART_ARB_TAG_EN
        ,
        TAG_LOW,
        TAG_HIGH
`endif
    } arb_state_t;

    // Placed in the MSB of a tag byte so a receiver can tell tags from data.
    localparam logic TAG_MARK = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector. The search starts at last+1 and wraps.
// The double-width request vector turns the wrap into a plain shift.
module rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                valid,
    output logic [ID_WIDTH-1:0] winner
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   start;
    int                   off;
    int                   sum;

    always_comb begin
        start = (int'(last) >= NUM_REQ - 1) ? 0 : int'(last) + 1;
        dbl   = {req, req};
        rot   = NUM_REQ'(dbl >> start);
        off   = 0;
        // Scanning from the top down leaves the lowest set offset in off.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = start + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        valid  = |req;
        winner = ID_WIDTH'(sum);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to precede every data byte with a requester tag byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_ready,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy
);

    arb_state_t           state, state_nxt;
    logic [ID_WIDTH-1:0]  last;
    logic                 pick_valid;
    logic [ID_WIDTH-1:0]  pick_id;
    logic [DATA_BITS-1:0] pick_byte;
    logic                 grant;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .winner(pick_id)
    );

    assign pick_byte = data[pick_id*DATA_BITS +: DATA_BITS];
    // The UART has no reset, so IDLE also waits out a frame left over from before rst.
    assign grant     = (state == IDLE) && pick_valid && tx_ready;

`ifdef UART_ARB_TAG_EN
    logic                 tag_phase;
    logic [DATA_BITS-1:0] data_lat;
    logic [DATA_BITS-1:0] tag_byte;

    if (DATA_BITS < ID_WIDTH + 1) begin : g_tag_width_check
        $error("uart_tx_arbiter: DATA_BITS too narrow for tag byte");
    end

    always_comb begin
        tag_byte                 = '0;
        tag_byte[ID_WIDTH-1:0]   = pick_id;
        tag_byte[DATA_BITS-1]    = TAG_MARK;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant) state_nxt = ISSUE;
`ifdef UART_ARB_TAG_EN
            ISSUE:     state_nxt = tag_phase ? TAG_LOW : WAIT_LOW;
            TAG_LOW:   if (!tx_ready) state_nxt = TAG_HIGH;
            TAG_HIGH:  if (tx_ready) state_nxt = ISSUE;
`else
            ISSUE:     state_nxt = WAIT_LOW;
`endif
            WAIT_LOW:  if (!tx_ready) state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (tx_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from state; rst masks them so a reset cycle never acks.
    always_comb begin
        ack      = '0;
        tx_start = (state == ISSUE) && !rst;
        busy     = (state != IDLE);
`ifdef UART_ARB_TAG_EN
        if (tx_start && !tag_phase) ack[grant_id] = 1'b1;
`else
        if (tx_start) ack[grant_id] = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id  <= '0;
            last      <= ID_WIDTH'(NUM_REQ - 1);
            tx_data   <= '0;
`ifdef UART_ARB_TAG_EN
            tag_phase <= 1'b0;
            data_lat  <= '0;
`endif
        end else if (grant) begin
            grant_id  <= pick_id;
            last      <= pick_id;
`ifdef UART_ARB_TAG_EN
            tx_data   <= tag_byte;
            data_lat  <= pick_byte;
            tag_phase <= 1'b1;
        end else if (state == TAG_HIGH && tx_ready) begin
            tx_data   <= data_lat;
            tag_phase <= 1'b0;
`else
            tx_data   <= pick_byte;
`endif
        end
    end

endmodule
